// File: rtl/tile_map_server_if.sv
// Collision query + map load bus between resolver/loader (master) and tile_map_server (slave).
interface tile_map_server_if;
  logic [9:0] x;
  logic [9:0] y;
  logic       blockType;
  logic       load_start;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       map_loaded;

  modport master (
    output x, y, load_start, load_valid, load_data,
    input  blockType, load_ready, map_loaded
  );

  modport slave (
    input  x, y, load_start, load_valid, load_data,
    output blockType, load_ready, map_loaded
  );
endinterface

// File: rtl/tile_map_server.sv
// 20x15 tile map (32-px tiles) with 1-cycle solid/empty query and byte-stream load FSM.
// Optional: define TILE_MAP_BORDER_EN to force the outer ring of tiles solid.
module tile_map_server (
  input  logic             clk,
  input  logic             rst_n,
  tile_map_server_if.slave bus
);
  localparam int TILES = 300;
  localparam logic [5:0] LAST_BYTE = 6'd37;

  typedef enum logic [1:0] {EMPTY, LOAD, READY} state_t;

  state_t           st_q;
  logic [5:0]       cnt_q;
  logic             load_ready_q, map_loaded_q, blk_q;
  logic [TILES-1:0] map_q;

  logic [4:0] col, row;
  logic [8:0] idx;
  logic       oob, border, tile_bit, accept;

  assign col = bus.x[9:5];
  assign row = bus.y[9:5];
  assign oob = (bus.x >= 10'd640) || (bus.y >= 10'd480);
  // row*20 + col as row*16 + row*4 + col; only meaningful when in bounds
  assign idx = {row, 4'b0} + {2'b0, row, 2'b0} + {4'b0, col};
  assign tile_bit = oob ? 1'b1 : map_q[idx];

`ifdef TILE_MAP_BORDER_EN
  assign border = (col == 5'd0) || (col == 5'd19) || (row == 5'd0) || (row == 5'd14);
`else
  assign border = 1'b0;
`endif

  // A restart pulse wins over a byte presented in the same cycle
  assign accept = (st_q == LOAD) && bus.load_valid && !bus.load_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blk_q <= 1'b1;
    else        blk_q <= !map_loaded_q || oob || border || tile_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q         <= EMPTY;
      cnt_q        <= '0;
      load_ready_q <= 1'b0;
      map_loaded_q <= 1'b0;
    end else begin
      case (st_q)
        EMPTY, READY: begin
          if (bus.load_start) begin
            st_q         <= LOAD;
            cnt_q        <= '0;
            load_ready_q <= 1'b1;
            map_loaded_q <= 1'b0;
          end
        end
        LOAD: begin
          if (bus.load_start) begin
            cnt_q <= '0;
          end else if (accept) begin
            if (cnt_q == LAST_BYTE) begin
              st_q         <= READY;
              cnt_q        <= '0;
              load_ready_q <= 1'b0;
              map_loaded_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
        end
        default: begin
          st_q         <= EMPTY;
          cnt_q        <= '0;
          load_ready_q <= 1'b0;
          map_loaded_q <= 1'b0;
        end
      endcase
    end
  end

  // Byte k lands on tiles 8k..8k+7; the padding bits past tile 299 have no storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      map_q <= '0;
    end else begin
      for (int t = 0; t < TILES; t++) begin
        if (accept && (cnt_q == 6'(t / 8)))
          map_q[t] <= bus.load_data[3'(t % 8)];
      end
    end
  end

  assign bus.blockType  = blk_q;
  assign bus.load_ready = load_ready_q;
  assign bus.map_loaded = map_loaded_q;
endmodule

// File: tb/tb_tile_map_server.sv
// Directed bench for tile_map_server: reset, loads with stall/restart, query table, pipelining.
module tb_tile_map_server;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  tile_map_server_if bus();

  tile_map_server dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       exp;
    string      name;
  } vec_t;

  int nvec  = 0;
  int nfail = 0;
  logic [7:0] img  [38];
  logic [7:0] zimg [38];
  vec_t vt [8];
  logic border_on;

  task automatic chk(input string name, input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic start_load();
    @(negedge clk);
    bus.load_start = 1'b1;
    bus.load_valid = 1'b0;
    @(negedge clk);
    bus.load_start = 1'b0;
    chk("load_ready_after_start", bus.load_ready, 1'b1);
    chk("map_loaded_after_start", bus.map_loaded, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] d);
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    @(negedge clk);
    bus.load_valid = 1'b0;
  endtask

  // Sends bytes from..37 of the image; map_loaded must stay low until the last one
  task automatic send_rest(input int from, input logic use_zero, input string tag);
    for (int k = from; k < 38; k++) begin
      send_byte(use_zero ? zimg[k] : img[k]);
      if (k == 36) chk({tag, "_loaded_before_last"}, bus.map_loaded, 1'b0);
      if (k == 37) begin
        chk({tag, "_loaded_on_last"}, bus.map_loaded, 1'b1);
        chk({tag, "_ready_low_after"}, bus.load_ready, 1'b0);
      end
    end
  endtask

  task automatic query(input logic [9:0] qx, input logic [9:0] qy, input logic exp,
                       input string name);
    @(negedge clk);
    bus.x = qx;
    bus.y = qy;
    @(negedge clk);
    chk(name, bus.blockType, exp);
  endtask

  initial begin
`ifdef TILE_MAP_BORDER_EN
    border_on = 1'b1;
`else
    border_on = 1'b0;
`endif
    // tiles 0,2 (byte 0) and tiles 21,23 (byte 2 bits 5,7) are solid
    for (int k = 0; k < 38; k++) begin
      img[k]  = 8'h00;
      zimg[k] = 8'h00;
    end
    img[0] = 8'h05;
    img[2] = 8'hA0;

    vt[0] = '{10'd0,   10'd0,   1'b1,      "q_0_0"};
    vt[1] = '{10'd32,  10'd0,   border_on, "q_32_0"};
    vt[2] = '{10'd64,  10'd0,   1'b1,      "q_64_0"};
    vt[3] = '{10'd640, 10'd0,   1'b1,      "oob_x640"};
    vt[4] = '{10'd0,   10'd480, 1'b1,      "oob_y480"};
    vt[5] = '{10'd0,   10'd992, 1'b1,      "oob_y992"};
    vt[6] = '{10'd608, 10'd448, border_on, "corner_608_448"};
    vt[7] = '{10'd100, 10'd100, 1'b0,      "q_100_100"};

    bus.x = 10'd100;
    bus.y = 10'd100;
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = 8'h00;

    // Reset held with queries active
    repeat (3) @(negedge clk);
    bus.x = 10'd32;
    @(negedge clk);
    chk("rst_blockType", bus.blockType, 1'b1);
    chk("rst_load_ready", bus.load_ready, 1'b0);
    chk("rst_map_loaded", bus.map_loaded, 1'b0);
    rst_n = 1'b1;
    query(10'd100, 10'd100, 1'b1, "unloaded_100_100");

    // Full load, then the query table
    start_load();
    send_rest(0, 1'b0, "load1");
    for (int i = 0; i < 8; i++) query(vt[i].x, vt[i].y, vt[i].exp, vt[i].name);

    // Back-to-back queries to tiles 21,22,23
    @(negedge clk);
    bus.x = 10'd32;  bus.y = 10'd32;
    @(negedge clk);
    chk("pipe_t21", bus.blockType, 1'b1);
    bus.x = 10'd64;
    @(negedge clk);
    chk("pipe_t22", bus.blockType, 1'b0);
    bus.x = 10'd96;
    @(negedge clk);
    chk("pipe_t23", bus.blockType, 1'b1);

    // Reload with a 5-cycle stall: counter must hold
    start_load();
    query(10'd100, 10'd100, 1'b1, "reload_unloaded_query");
    for (int k = 0; k < 10; k++) send_byte(img[k]);
    repeat (5) begin
      @(negedge clk);
      chk("stall_ready_held", bus.load_ready, 1'b1);
    end
    send_rest(10, 1'b0, "stall");

    // Restart at byte 20 with a byte presented alongside the pulse (dropped)
    start_load();
    for (int k = 0; k < 20; k++) send_byte(img[k]);
    @(negedge clk);
    bus.load_start = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data  = 8'hFF;
    @(negedge clk);
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    chk("restart_ready", bus.load_ready, 1'b1);
    send_rest(0, 1'b0, "restart");
    query(10'd32, 10'd256, 1'b0, "dropped_byte_t161");
    query(10'd96, 10'd32, 1'b1, "after_restart_t23");

    // Reset in the middle of a load
    start_load();
    for (int k = 0; k < 10; k++) send_byte(8'hFF);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", bus.load_ready, 1'b0);
    chk("midrst_loaded", bus.map_loaded, 1'b0);
    chk("midrst_blockType", bus.blockType, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    query(10'd64, 10'd64, 1'b1, "midrst_unloaded_64_64");
    start_load();
    send_rest(0, 1'b1, "zero");
    query(10'd64, 10'd64, 1'b0, "zero_64_64");
    query(10'd64, 10'd0, border_on, "zero_64_0");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
